// File: rtl/palette_pkg.sv
// Shared types and helpers for the score/sprite colour palette.
//   rgb_t         : packed {r, g, b} colour word, COLOR_W bits per channel
//   state_t       : palette init FSM states
//   default_color : power-on colour for a palette index
//   invert_rgb    : per-channel colour inversion used by blink mode
package palette_pkg;

  localparam int COLOR_W = 4;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb_t;

  typedef enum logic {INIT, RUN} state_t;

  // Black/white checker by the two low index bits: 0->black, 1,2->white, 3->black.
  function automatic rgb_t default_color(input logic [1:0] idx);
    rgb_t c;
    logic bitv;
    bitv = idx[0] ^ idx[1];
    c.r  = {COLOR_W{bitv}};
    c.g  = {COLOR_W{bitv}};
    c.b  = {COLOR_W{bitv}};
    return c;
  endfunction

  // Bitwise NOT of a channel equals (2**COLOR_W-1) - channel.
  function automatic rgb_t invert_rgb(input rgb_t c);
    rgb_t o;
    o.r = ~c.r;
    o.g = ~c.g;
    o.b = ~c.b;
    return o;
  endfunction

endpackage

// File: rtl/palette_bank_ram.sv
// Simple dual-port palette storage, flattened {bank, index} addressing.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address
//   wdata_i  : write data
//   raddr_i  : read address
//   rdata_o  : registered read data (old contents on same-address write)
module palette_bank_ram #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 12
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Read and write in the same block give read-before-write on collisions.
  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/score_palette_ram.sv
// Runtime-writable multi-bank colour palette with 2-stage read pipeline.
//   Clk, Reset                      : clock, async active-high reset
//   pix_valid/pix_index/pix_bank    : read request
//   rgb_out/out_valid/transparent   : registered read result, 2 cycles later
//   wr_en/wr_bank/wr_addr/wr_data   : write request, accepted when wr_ready
//   wr_ready                        : high once default load is complete
//   frame_tick/blink_en             : frame-synchronous colour-invert blink
//   init_busy                       : default palette load in progress
// COLOR_W must match palette_pkg::COLOR_W (rgb_t is defined there).
module score_palette_ram
  import palette_pkg::*;
#(
  parameter int INDEX_W      = 4,
  parameter int COLOR_W      = palette_pkg::COLOR_W,
  parameter int NUM_BANKS    = 4,
  parameter int TRANSP_IDX   = 0,
  parameter int BLINK_FRAMES = 30,
  localparam int BANK_W      = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 pix_valid,
  input  logic [INDEX_W-1:0]   pix_index,
  input  logic [BANK_W-1:0]    pix_bank,
  output logic [3*COLOR_W-1:0] rgb_out,
  output logic                 out_valid,
  output logic                 transparent,
  input  logic                 wr_en,
  input  logic [BANK_W-1:0]    wr_bank,
  input  logic [INDEX_W-1:0]   wr_addr,
  input  logic [3*COLOR_W-1:0] wr_data,
  output logic                 wr_ready,
  input  logic                 frame_tick,
  input  logic                 blink_en,
  output logic                 init_busy
);

  localparam int ENTRIES = 2**INDEX_W;
  localparam int ADDR_W  = BANK_W + INDEX_W;
  localparam int TOTAL   = NUM_BANKS * ENTRIES;
  localparam int CNT_W   = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [ADDR_W-1:0]  LAST_ADDR  = ADDR_W'(TOTAL - 1);
  localparam logic [BANK_W:0]    BANKS_L    = (BANK_W + 1)'(NUM_BANKS);
  localparam logic [INDEX_W-1:0] TRANSP_L   = INDEX_W'(TRANSP_IDX);
  localparam logic [CNT_W-1:0]   BLINK_LAST = CNT_W'(BLINK_FRAMES - 1);

  state_t            state_q;
  logic [ADDR_W-1:0] init_ptr_q;
  logic              init_busy_q, wr_ready_q;
  logic              run;

  // Init FSM: bank-major fill of every entry with its default colour.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= INIT;
      init_ptr_q  <= '0;
      init_busy_q <= 1'b1;
      wr_ready_q  <= 1'b0;
    end else begin
      case (state_q)
        INIT: begin
          if (init_ptr_q == LAST_ADDR) begin
            state_q     <= RUN;
            init_busy_q <= 1'b0;
            wr_ready_q  <= 1'b1;
          end else begin
            init_ptr_q <= init_ptr_q + 1'b1;
          end
        end
        RUN: ;
        default: state_q <= INIT;
      endcase
    end
  end

  assign run       = (state_q == RUN);
  assign init_busy = init_busy_q;
  assign wr_ready  = wr_ready_q;

  // RAM port muxing: init loader owns the write port until RUN.
  logic              rd_in_range, wr_in_range;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  rgb_t              ram_wdata, ram_rdata;

  assign rd_in_range = ({1'b0, pix_bank} < BANKS_L);
  assign wr_in_range = ({1'b0, wr_bank} < BANKS_L);

  always_comb begin
    ram_we    = 1'b0;
    ram_waddr = {wr_bank, wr_addr};
    ram_wdata = rgb_t'(wr_data);
    if (!run) begin
      ram_we    = 1'b1;
      ram_waddr = init_ptr_q;
      ram_wdata = default_color(init_ptr_q[1:0]);
    end else if (wr_en && wr_in_range) begin
      ram_we = 1'b1;
    end
  end

  palette_bank_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (3 * COLOR_W)
  ) u_ram (
    .clk_i   (Clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .raddr_i ({pix_bank, pix_index}),
    .rdata_o (ram_rdata)
  );

  // Blink counter and phase.
  logic [CNT_W-1:0] blink_cnt_q;
  logic             phase_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (!blink_en) begin
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else if (frame_tick && run) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        phase_q     <= ~phase_q;
      end else begin
        blink_cnt_q <= blink_cnt_q + 1'b1;
      end
    end
  end

  // Stage 1: side-band alongside the registered RAM read.
  logic v1_q, tr1_q, ph1_q, ok1_q;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      v1_q  <= 1'b0;
      tr1_q <= 1'b0;
      ph1_q <= 1'b0;
      ok1_q <= 1'b0;
    end else begin
      v1_q  <= pix_valid && run;
      tr1_q <= (pix_index == TRANSP_L);
      ph1_q <= phase_q;
      ok1_q <= rd_in_range;
    end
  end

  // Stage 2: invert and register outputs; rgb holds when no valid read.
  rgb_t rd_data, rgb_d, rgb_q;
  logic out_valid_q, transp_q;

  always_comb begin
    rd_data = ok1_q ? ram_rdata : '0;
    rgb_d   = ph1_q ? invert_rgb(rd_data) : rd_data;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rgb_q       <= '0;
      out_valid_q <= 1'b0;
      transp_q    <= 1'b0;
    end else begin
      out_valid_q <= v1_q;
      transp_q    <= v1_q && tr1_q;
      if (v1_q) rgb_q <= rgb_d;
    end
  end

  assign rgb_out     = rgb_q;
  assign out_valid   = out_valid_q;
  assign transparent = transp_q;

endmodule

// File: tb/tb_score_palette_ram.sv
module tb_score_palette_ram;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        pix_valid;
  logic [3:0]  pix_index;
  logic [1:0]  pix_bank;
  logic [11:0] rgb_out;
  logic        out_valid;
  logic        transparent;
  logic        wr_en;
  logic [1:0]  wr_bank;
  logic [3:0]  wr_addr;
  logic [11:0] wr_data;
  logic        wr_ready;
  logic        frame_tick;
  logic        blink_en;
  logic        init_busy;

  score_palette_ram #(
    .INDEX_W      (4),
    .NUM_BANKS    (4),
    .TRANSP_IDX   (0),
    .BLINK_FRAMES (2)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .pix_valid   (pix_valid),
    .pix_index   (pix_index),
    .pix_bank    (pix_bank),
    .rgb_out     (rgb_out),
    .out_valid   (out_valid),
    .transparent (transparent),
    .wr_en       (wr_en),
    .wr_bank     (wr_bank),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .frame_tick  (frame_tick),
    .blink_en    (blink_en),
    .init_busy   (init_busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [11:0] rgb;
    logic        tr;
    int          due;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  bank;
    logic [3:0]  idx;
    logic [11:0] rgb;
  } vec_t;
  vec_t vecs[20];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Called at a negedge: request is sampled at the next posedge.
  task automatic rd(input logic [1:0] b, input logic [3:0] i, input logic [11:0] e);
    exp_t x;
    pix_valid = 1'b1;
    pix_bank  = b;
    pix_index = i;
    x.rgb = e;
    x.tr  = (i == 4'd0);
    x.due = cyc + 2;
    sb.push_back(x);
  endtask

  task automatic wr(input logic [1:0] b, input logic [3:0] a, input logic [11:0] d);
    wr_en   = 1'b1;
    wr_bank = b;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge Clk);
    frame_tick = 1'b0;
    @(negedge Clk);
  endtask

  task automatic wait_init();
    int n;
    n = 0;
    while (init_busy && n < 200) begin
      @(posedge Clk);
      #1;
      n++;
      if (n == 60) pix_valid = 1'b0;
    end
    chk("init_cycles", n, 64);
    chk("wr_ready_after_init", wr_ready, 1);
  endtask

  // Output monitor / scoreboard.
  always begin
    exp_t x;
    @(posedge Clk);
    cyc++;
    #1;
    if (!Reset) begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out_valid: got 1 expected 0 (cyc %0d)", cyc);
        end else begin
          x = sb.pop_front();
          chk("rgb", rgb_out, x.rgb);
          chk("transparent", transparent, x.tr);
          chk("latency", cyc, x.due);
        end
      end else begin
        if (transparent) begin
          total++;
          bad++;
          $display("FAIL transp_when_invalid: got 1 expected 0");
        end
        if (sb.size() > 0 && sb[0].due <= cyc) begin
          x = sb.pop_front();
          total++;
          bad++;
          $display("FAIL missing_out_valid: got 0 expected 1 (due %0d)", x.due);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{2'd2, 4'd0, 12'h000};
    vecs[1] = '{2'd2, 4'd1, 12'hFFF};
    vecs[2] = '{2'd2, 4'd2, 12'hFFF};
    vecs[3] = '{2'd2, 4'd3, 12'h000};
    for (int i = 0; i < 16; i++) begin
      vecs[4+i].bank = 2'd3;
      vecs[4+i].idx  = 4'(i);
      vecs[4+i].rgb  = ((i % 4 == 1) || (i % 4 == 2)) ? 12'hFFF : 12'h000;
    end

    Reset = 1'b1; pix_valid = 1'b0; pix_index = '0; pix_bank = '0;
    wr_en = 1'b0; wr_bank = '0; wr_addr = '0; wr_data = '0;
    frame_tick = 1'b0; blink_en = 1'b0;
    #1;
    chk("rst_rgb", rgb_out, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_transparent", transparent, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_init_busy", init_busy, 1);

    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    // Reads during INIT must be ignored; frame ticks too.
    pix_valid = 1'b1; pix_bank = 2'd0; pix_index = 4'd1;
    frame_tick = 1'b1;
    wait_init();
    frame_tick = 1'b0;

    // Default palette, bank 2, back-to-back.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      rd(vecs[i].bank, vecs[i].idx, vecs[i].rgb);
    end
    @(negedge Clk); pix_valid = 1'b0;

    // Write then read next cycle; other bank unaffected.
    @(negedge Clk); wr(2'd1, 4'd5, 12'h3A7);
    @(negedge Clk); wr_en = 1'b0; rd(2'd1, 4'd5, 12'h3A7);
    @(negedge Clk); rd(2'd0, 4'd5, 12'hFFF);
    @(negedge Clk); pix_valid = 1'b0;

    // Same-address collision: old data, then new.
    @(negedge Clk); wr(2'd0, 4'd3, 12'h123); rd(2'd0, 4'd3, 12'h000);
    @(negedge Clk); wr_en = 1'b0; rd(2'd0, 4'd3, 12'h123);
    @(negedge Clk); pix_valid = 1'b0;

    // 16-read stream, full throughput.
    for (int i = 4; i < 20; i++) begin
      @(negedge Clk);
      rd(vecs[i].bank, vecs[i].idx, vecs[i].rgb);
    end
    @(negedge Clk); pix_valid = 1'b0;
    repeat (4) @(negedge Clk);

    // Blink with BLINK_FRAMES = 2.
    blink_en = 1'b1;
    @(negedge Clk);
    tick();
    rd(2'd1, 4'd5, 12'h3A7);
    @(negedge Clk); pix_valid = 1'b0;
    tick();
    rd(2'd1, 4'd5, 12'hC58);
    @(negedge Clk); rd(2'd1, 4'd0, 12'hFFF);
    @(negedge Clk); pix_valid = 1'b0;
    tick();
    tick();
    rd(2'd1, 4'd5, 12'h3A7);
    @(negedge Clk); pix_valid = 1'b0;
    tick();
    tick();
    rd(2'd1, 4'd5, 12'hC58);
    @(negedge Clk); pix_valid = 1'b0; blink_en = 1'b0;
    @(negedge Clk); rd(2'd1, 4'd5, 12'h3A7);
    @(negedge Clk); pix_valid = 1'b0;
    repeat (4) @(negedge Clk);

    // Reset in the middle of a read stream.
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      rd(2'd2, 4'(i), vecs[i].rgb);
    end
    #2;
    Reset = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_init_busy", init_busy, 1);
    chk("midrst_wr_ready", wr_ready, 0);
    sb.delete();
    pix_valid = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    wait_init();
    @(negedge Clk); rd(2'd1, 4'd5, 12'hFFF);
    @(negedge Clk); pix_valid = 1'b0;
    repeat (6) @(negedge Clk);
    chk("scoreboard_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
